uvma_apb_regfile_slv: RTL and testbench
=======================================

UVMA_APB_REGFILE_SLV -- requirements
Module: uvma_apb_regfile_slv

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the reset is synchronous and active-high.
REQ-002 The block SHALL have parameter ADDR_W, default 12, PADDR width in bits.
REQ-003 The block SHALL have parameter DATA_W, default 32, PWDATA/PRDATA width (legal values 8, 16, 32, 64).
REQ-004 The block SHALL have parameter NUM_REGS, default 16, total register count (2..256).
REQ-005 The block SHALL have parameter NUM_RO, default 4, read-only register count (0..NUM_REGS-1); RO registers are indices NUM_REGS-NUM_RO..NUM_REGS-1.
REQ-006 The block SHALL have parameter WAIT_CYCLES, default 0, wait states inserted per transfer (0..15).
REQ-007 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-008 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-009 The block SHALL have ports paddr (input, ADDR_W), psel (input, 1), penable (input, 1), pwrite (input, 1) and pwdata (input, DATA_W), the APB4 requester signals.
REQ-010 The block SHALL have port pstrb, input, DATA_W/8 bits, write byte strobes.
REQ-011 The block SHALL have ports pready (output, 1), prdata (output, DATA_W) and pslverr (output, 1), the completer response.
REQ-012 The block SHALL have port ro_data, input, NUM_RO*DATA_W bits, live values of the RO registers (register NUM_REGS-NUM_RO in the LSBs).
REQ-013 The block SHALL have port rw_data, output, (NUM_REGS-NUM_RO)*DATA_W bits, current RW register contents.
REQ-014 The block SHALL have port wr_pulse, output, NUM_REGS-NUM_RO bits, one-cycle strobe per RW register written.
REQ-015 The block SHALL have port proto_err, output, 1 bit, one-cycle protocol-violation strobe.

Function
REQ-016 The FSM SHALL have two states, IDLE and ACCESS, and a 4-bit wait counter wcnt.
REQ-017 In IDLE, psel=1 with penable=0 (SETUP) SHALL move the FSM to ACCESS with wcnt=WAIT_CYCLES and capture paddr and pwrite.
REQ-018 In IDLE, psel=1 with penable=1 SHALL pulse proto_err for one cycle and keep the FSM in IDLE; no register SHALL change.
REQ-019 In ACCESS, pready SHALL be combinationally 1 only when wcnt==0 and psel=1 and penable=1; otherwise pready SHALL be 0.
REQ-020 In ACCESS with wcnt!=0 and psel=penable=1, wcnt SHALL decrement by 1 per cycle.
REQ-021 A cycle with pready=1 is the completion cycle, and the FSM SHALL return to IDLE on the next clock edge; an immediately following SETUP is therefore sampled in IDLE, giving back-to-back transfers with no dead cycle.
REQ-022 In ACCESS, psel=0, or paddr or pwrite differing from the captured values, SHALL pulse proto_err, abort the transfer without any write, and return the FSM to IDLE.
REQ-023 The word index SHALL be paddr[ADDR_W-1:log2(DATA_W/8)].
REQ-024 An access is an error if the index is >= NUM_REGS, or paddr[log2(DATA_W/8)-1:0]!=0, or it is a write to an RO index.
REQ-025 pslverr SHALL equal the error flag during the completion cycle and be 0 at all other times.
REQ-026 A non-error write SHALL update, on the completion edge, every byte lane i of the RW register whose pstrb[i]=1; lanes with pstrb[i]=0 SHALL hold their value.
REQ-027 A non-error write SHALL pulse wr_pulse[index] in the cycle after completion, including when pstrb is all zeros.
REQ-028 An erroring access SHALL modify no register and SHALL NOT pulse wr_pulse.
REQ-029 During a read completion cycle, prdata SHALL be the RW register or the ro_data slice for the index; prdata SHALL be 0 on error, on writes, and whenever pready=0.
REQ-030 rw_data SHALL reflect register contents combinationally from the flops.

Reset
REQ-031 While reset=1 at a rising edge, the FSM SHALL enter IDLE, wcnt SHALL become 0, and all RW registers SHALL become 0.
REQ-032 While reset=1, wr_pulse and proto_err SHALL be 0, and pready, pslverr and prdata SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no write and no proto_err.
REQ-034 The first SETUP SHALL be accepted in the first cycle after reset deasserts.

Verification
REQ-035 Defaults, write 0xA5A5_5A5A to paddr 0x008 with pstrb=4'b0101 and register 2 previously 0 -> pready high in the 2nd cycle, rw_data reg2=0x00A5_005A, and wr_pulse[2] asserts in the next cycle.
REQ-036 WAIT_CYCLES=3, read of paddr 0x000 -> pready low for 3 ACCESS cycles and high on the 4th, with prdata = reg0 only in that cycle.
REQ-037 Write to paddr 0x030 (RO register 12) and read of paddr 0x040 (out of range) -> pslverr=1 on completion, prdata=0, no register change, no wr_pulse.
REQ-038 Unaligned read of paddr 0x006 -> pslverr=1 and prdata=0.
REQ-039 Requester drops psel during a wait state (WAIT_CYCLES=2), and separately asserts psel=penable=1 from IDLE -> one proto_err pulse each, FSM in IDLE, no write.
REQ-040 Back-to-back write to reg1 then read of reg1, and reset asserted during the ACCESS of a write -> read returns the written value with no idle cycle between transfers; after reset all rw_data=0 and the aborted write is not applied.

Source files
------------

// File: rtl/uvma_apb_regfile_slv.sv
// APB4 completer for a register file. RW registers use the low indices and live
// read-only inputs use the top indices. Wait states are optional; wr_pulse and proto_err are registered strobes.
module uvma_apb_regfile_slv #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int NUM_RO      = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ADDR_W-1:0]                   paddr,
    input  logic                                psel,
    input  logic                                penable,
    input  logic                                pwrite,
    input  logic [DATA_W-1:0]                   pwdata,
    input  logic [DATA_W/8-1:0]                 pstrb,
    output logic                                pready,
    output logic [DATA_W-1:0]                   prdata,
    output logic                                pslverr,
    input  logic [NUM_RO*DATA_W-1:0]            ro_data,
    output logic [(NUM_REGS-NUM_RO)*DATA_W-1:0] rw_data,
    output logic [NUM_REGS-NUM_RO-1:0]          wr_pulse,
    output logic                                proto_err
);
    localparam int NUM_RW = NUM_REGS - NUM_RO;
    localparam int NUM_LN = DATA_W / 8;
    localparam int LSB    = $clog2(NUM_LN);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << LSB) - 1);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] rw_q [NUM_RW];
    logic [DATA_W-1:0] rw_d [NUM_RW];
    logic [NUM_RW-1:0] wr_pulse_q, wr_pulse_d;
    logic              proto_err_q, proto_err_d;

    logic              complete;
    logic              violation;
    logic [31:0]       word_idx;
    logic              access_err;
    logic [DATA_W-1:0] rd_word;

    // Decode uses the captured address. Any change in paddr during ACCESS is a violation.
    always_comb begin
        word_idx   = 32'(addr_q >> LSB);
        access_err = (word_idx >= 32'(NUM_REGS))
                   || ((addr_q & OFF_MASK) != '0)
                   || (write_q && (word_idx >= 32'(NUM_RW)));
    end

    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_RW; r++) begin
            if (word_idx == 32'(r)) rd_word = rw_q[r];
        end
        for (int r = 0; r < NUM_RO; r++) begin
            if (word_idx == 32'(NUM_RW + r)) rd_word = ro_data[r*DATA_W +: DATA_W];
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        complete  = 1'b0;
        violation = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    wcnt_d  = WAIT_INIT;
                    addr_d  = paddr;
                    write_d = pwrite;
                end else if (psel && penable) begin
                    violation = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel || (paddr != addr_q) || (pwrite != write_q)) begin
                    violation = 1'b1;
                    state_d   = IDLE;
                    wcnt_d    = '0;
                end else if (penable) begin
                    if (wcnt_q == '0) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pready      = complete && !reset;
    assign pslverr     = pready && access_err;
    assign prdata      = (pready && !write_q && !access_err) ? rd_word : '0;
    assign proto_err_d = violation && !reset;

    always_comb begin
        rw_d       = rw_q;
        wr_pulse_d = '0;
        if (pready && write_q && !access_err) begin
            for (int r = 0; r < NUM_RW; r++) begin
                if (word_idx == 32'(r)) begin
                    wr_pulse_d[r] = 1'b1;
                    for (int b = 0; b < NUM_LN; b++) begin
                        if (pstrb[b]) rw_d[r][b*8 +: 8] = pwdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // NOTE: state elements use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wr_pulse_q  <= '0;
            proto_err_q <= 1'b0;
            // NOTE: the register file is reset because software relies on reading zeros.
            for (int r = 0; r < NUM_RW; r++) rw_q[r] <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wr_pulse_q  <= wr_pulse_d;
            proto_err_q <= proto_err_d;
            for (int r = 0; r < NUM_RW; r++) rw_q[r] <= rw_d[r];
        end
    end

    assign wr_pulse  = reset ? '0 : wr_pulse_q;
    assign proto_err = proto_err_q && !reset;

    for (genvar r = 0; r < NUM_RW; r++) begin : g_rw_out
        assign rw_data[r*DATA_W +: DATA_W] = rw_q[r];
    end

endmodule

// File: tb/tb_uvma_apb_regfile_slv.sv
// Bench for uvma_apb_regfile_slv with three instances: WAIT_CYCLES 0, 3 and 2.
// Table-driven vectors run on the zero-wait instance, plus hand-written corner sequences.
module tb_uvma_apb_regfile_slv;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int NRO = 4;
    localparam int NRW = NR - NRO;
    localparam int ND  = 3;
    localparam int NV  = 14;

    logic           clk = 1'b0;
    logic           reset;
    logic [AW-1:0]  paddr   [ND];
    logic           psel    [ND];
    logic           penable [ND];
    logic           pwrite  [ND];
    logic [DW-1:0]  pwdata  [ND];
    logic [DW/8-1:0] pstrb  [ND];
    logic           pready  [ND];
    logic [DW-1:0]  prdata  [ND];
    logic           pslverr [ND];
    logic [NRW*DW-1:0] rw_data [ND];
    logic [NRW-1:0] wr_pulse  [ND];
    logic           proto_err [ND];
    logic [NRO*DW-1:0] ro_data;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        uvma_apb_regfile_slv #(
            .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .NUM_RO(NRO),
            .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) u_dut (
            .clk(clk), .reset(reset),
            .paddr(paddr[g]), .psel(psel[g]), .penable(penable[g]), .pwrite(pwrite[g]),
            .pwdata(pwdata[g]), .pstrb(pstrb[g]),
            .pready(pready[g]), .prdata(prdata[g]), .pslverr(pslverr[g]),
            .ro_data(ro_data), .rw_data(rw_data[g]),
            .wr_pulse(wr_pulse[g]), .proto_err(proto_err[g])
        );
    end

    typedef struct {
        logic [AW-1:0]  addr;
        logic           wr;
        logic [DW-1:0]  wdata;
        logic [3:0]     strb;
        logic           exp_err;
        logic [DW-1:0]  exp_rdata;
        logic [NRW-1:0] exp_pulse;
    } vec_t;

    vec_t          vecs [NV];
    logic [DW-1:0] shadow [NRW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rw_word(input int d, input int r);
        return rw_data[d][r*DW +: DW];
    endfunction

    task automatic check_regs(input string tag, input int d);
        for (int r = 0; r < NRW; r++)
            check($sformatf("%s_reg%0d", tag, r), rw_word(d, r), shadow[r]);
    endtask

    // Starts at posedge+1 (or at a negedge). Returns at posedge+1 in the cycle after completion.
    task automatic xfer(input int d, input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] wd, input logic [3:0] st,
                        output logic [DW-1:0] rd, output logic err,
                        output int waits, output int done_cyc);
        logic seen;
        seen = 1'b0; rd = '0; err = 1'b0; waits = 0; done_cyc = 0;
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = w;
        pwdata[d] = wd; pstrb[d] = st;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pready[d]) begin
                seen = 1'b1; rd = prdata[d]; err = pslverr[d]; done_cyc = cyc;
            end else begin
                waits++;
                check("prdata_during_wait", prdata[d], 0);
                check("pslverr_during_wait", pslverr[d], 0);
            end
            @(posedge clk); #1;
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
        check("pready_seen", seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic          err;
        int            waits, dc1, dc2, idx;

        vecs[0]  = '{12'h008, 1'b1, 32'hA5A5_5A5A, 4'b0101, 1'b0, 32'h0,         12'h004};
        vecs[1]  = '{12'h008, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h00A5_005A, 12'h000};
        vecs[2]  = '{12'h008, 1'b1, 32'hFFFF_FFFF, 4'b1000, 1'b0, 32'h0,         12'h004};
        vecs[3]  = '{12'h004, 1'b1, 32'h1234_5678, 4'b0000, 1'b0, 32'h0,         12'h002};
        vecs[4]  = '{12'h02C, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,         12'h800};
        vecs[5]  = '{12'h02C, 1'b0, 32'h0,         4'b0000, 1'b0, 32'hDEAD_BEEF, 12'h000};
        vecs[6]  = '{12'h030, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h1200_00C0, 12'h000};
        vecs[7]  = '{12'h03C, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h1500_00F0, 12'h000};
        vecs[8]  = '{12'h030, 1'b1, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0,         12'h000};
        vecs[9]  = '{12'h040, 1'b0, 32'h0,         4'b0000, 1'b1, 32'h0,         12'h000};
        vecs[10] = '{12'h006, 1'b0, 32'h0,         4'b0000, 1'b1, 32'h0,         12'h000};
        vecs[11] = '{12'h00A, 1'b1, 32'h1111_1111, 4'b1111, 1'b1, 32'h0,         12'h000};
        vecs[12] = '{12'hFFC, 1'b1, 32'h0000_0001, 4'b1111, 1'b1, 32'h0,         12'h000};
        vecs[13] = '{12'h000, 1'b0, 32'h0,         4'b0000, 1'b0, 32'h0,         12'h000};

        ro_data = {32'h1500_00F0, 32'h1400_00E0, 32'h1300_00D0, 32'h1200_00C0};
        for (int r = 0; r < NRW; r++) shadow[r] = '0;
        for (int d = 0; d < ND; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
        end

        // Reset, with an illegal psel+penable on instance 0 that must stay silent.
        reset = 1'b1;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_pready%0d", d), pready[d], 0);
            check($sformatf("rst_pslverr%0d", d), pslverr[d], 0);
            check($sformatf("rst_prdata%0d", d), prdata[d], 0);
            check($sformatf("rst_proto_err%0d", d), proto_err[d], 0);
            check($sformatf("rst_wr_pulse%0d", d), wr_pulse[d], 0);
        end
        @(posedge clk); #1;
        reset = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        check("post_rst_proto_err", proto_err[0], 0);
        check_regs("post_rst", 0);
        @(posedge clk); #1;

        // Table-driven vectors on the zero-wait instance.
        for (int i = 0; i < NV; i++) begin
            xfer(0, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, rd, err, waits, dc1);
            check($sformatf("v%0d_pslverr", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_waits", i), waits, 0);
            if (vecs[i].wr && !vecs[i].exp_err) begin
                idx = int'(vecs[i].addr >> 2);
                for (int b = 0; b < 4; b++)
                    if (vecs[i].strb[b]) shadow[idx][b*8 +: 8] = vecs[i].wdata[b*8 +: 8];
            end
            @(negedge clk);
            check($sformatf("v%0d_wr_pulse", i), wr_pulse[0], vecs[i].exp_pulse);
            check_regs($sformatf("v%0d", i), 0);
        end
        check("v0_reg2_literal", rw_word(0, 2), 32'hFFA5_005A);

        // Three wait states: write, then read reg0 through instance 1.
        @(posedge clk); #1;
        xfer(1, 12'h000, 1'b1, 32'h0BAD_F00D, 4'b1111, rd, err, waits, dc1);
        check("w3_write_waits", waits, 3);
        check("w3_write_err", err, 0);
        @(negedge clk);
        check("w3_wr_pulse", wr_pulse[1], 12'h001);
        @(posedge clk); #1;
        xfer(1, 12'h000, 1'b0, 32'h0, 4'b0000, rd, err, waits, dc1);
        check("w3_read_waits", waits, 3);
        check("w3_read_data", rd, 32'h0BAD_F00D);
        check("w3_read_err", err, 0);

        // Instance 2 drops psel during a wait state.
        psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 12'h000; pwrite[2] = 1'b1;
        pwdata[2] = 32'hFFFF_FFFF; pstrb[2] = 4'hF;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(negedge clk);
        check("drop_pready_wait", pready[2], 0);
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge clk);
        check("drop_proto_err_early", proto_err[2], 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_proto_err", proto_err[2], 1);
        check("drop_wr_pulse", wr_pulse[2], 0);
        check("drop_reg0", rw_word(2, 0), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("drop_proto_err_once", proto_err[2], 0);
        @(posedge clk); #1;
        xfer(2, 12'h000, 1'b0, 32'h0, 4'b0000, rd, err, waits, dc1);
        check("drop_then_read_waits", waits, 2);
        check("drop_then_read_data", rd, 0);

        // Instance 2 receives psel and penable together while IDLE.
        psel[2] = 1'b1; penable[2] = 1'b1; paddr[2] = 12'h000; pwrite[2] = 1'b1;
        pwdata[2] = 32'hFFFF_FFFF; pstrb[2] = 4'hF;
        @(negedge clk);
        check("idle_pe_pready", pready[2], 0);
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge clk);
        check("idle_pe_proto_err", proto_err[2], 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_pe_proto_err_once", proto_err[2], 0);
        check("idle_pe_reg0", rw_word(2, 0), 0);
        check("idle_pe_wr_pulse", wr_pulse[2], 0);
        @(posedge clk); #1;
        xfer(2, 12'h004, 1'b0, 32'h0, 4'b0000, rd, err, waits, dc1);
        check("idle_pe_then_read_waits", waits, 2);

        // Back-to-back transfers on instance 0: write reg1, then read reg1 with no idle cycle.
        xfer(0, 12'h004, 1'b1, 32'hCAFE_1234, 4'b1111, rd, err, waits, dc1);
        xfer(0, 12'h004, 1'b0, 32'h0, 4'b0000, rd, err, waits, dc2);
        check("b2b_read_data", rd, 32'hCAFE_1234);
        check("b2b_spacing", dc2 - dc1, 2);

        // Reset during the ACCESS of a write.
        psel[0] = 1'b1; penable[0] = 1'b0; paddr[0] = 12'h004; pwrite[0] = 1'b1;
        pwdata[0] = 32'h5555_5555; pstrb[0] = 4'hF;
        @(posedge clk); #1;
        penable[0] = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("mid_rst_pready", pready[0], 0);
        check("mid_rst_pslverr", pslverr[0], 0);
        check("mid_rst_prdata", prdata[0], 0);
        check("mid_rst_proto_err", proto_err[0], 0);
        @(posedge clk); #1;
        reset = 1'b0; psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge clk);
        check("after_rst_proto_err", proto_err[0], 0);
        check("after_rst_wr_pulse", wr_pulse[0], 0);
        for (int r = 0; r < NRW; r++) shadow[r] = '0;
        check_regs("after_rst", 0);
        xfer(0, 12'h004, 1'b0, 32'h0, 4'b0000, rd, err, waits, dc1);
        check("first_setup_waits", waits, 0);
        check("first_setup_data", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
